icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the CPU fetch port and the block-wide instruction memory.
- Responder side of the CPU fetch interface: takes the PC-derived byte address, returns the 32-bit instruction, and stalls the CPU with BUSYWAIT on a miss.
- On a miss, fetches a full 16-byte block from instruction memory through a read/busywait handshake.

---
 rtl/icache_direct.sv | 141 ++++++++++++++
 tb/tb_icache_direct.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with block refill
// Ports:
//   CLK, RESET            clock; asynchronous active-high reset
//   ADDRESS               fetch byte address, bits [1:0] ignored
//   INSTRUCTION, BUSYWAIT fetched word (valid when BUSYWAIT=0), CPU stall
//   MEM_READ, MEM_ADDRESS block read request and block address to memory
//   MEM_READDATA          128-bit block, word0 in [31:0]
//   MEM_BUSYWAIT          memory busy; data valid the cycle it falls while MEM_READ=1
//   HIT_COUNT, MISS_COUNT saturating statistics, only with ICACHE_STATS_EN defined
module icache_direct #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BLOCKS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-5:0] MEM_ADDRESS,
  input  logic [127:0]          MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
`endif
);

  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W   = ADDR_WIDTH - 4 - INDEX_W;
  localparam int BADDR_W = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {S_IDLE, S_MREAD, S_UPDATE} state_t;

  state_t               state;
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_BLOCKS];
  logic [127:0]         data_mem [NUM_BLOCKS];
  logic [BADDR_W-1:0]   fill_addr;
  logic [127:0]         fill_data;
  logic                 mem_read_q;

  logic [1:0]           off;
  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic [INDEX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 hit;
  logic [127:0]         line;
  logic [31:0]          word;
  logic                 addr_unused;

  assign off         = ADDRESS[3:2];
  assign idx         = ADDRESS[3+INDEX_W:4];
  assign tag         = ADDRESS[ADDR_WIDTH-1:4+INDEX_W];
  assign fill_idx    = fill_addr[INDEX_W-1:0];
  assign fill_tag    = fill_addr[BADDR_W-1:INDEX_W];
  assign addr_unused = ^ADDRESS[1:0];

  assign hit  = valid[idx] && (tag_mem[idx] == tag);
  assign line = data_mem[idx];

  always_comb begin
    word = line[31:0];
    case (off)
      2'd0: word = line[31:0];
      2'd1: word = line[63:32];
      2'd2: word = line[95:64];
      2'd3: word = line[127:96];
      default: word = line[31:0];
    endcase
  end

  // Hit path is purely combinational from ADDRESS; RESET forces a quiet port.
  assign BUSYWAIT    = !RESET && ((state != S_IDLE) || !hit);
  assign INSTRUCTION = (!RESET && (state == S_IDLE) && hit) ? word : 32'd0;
  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = mem_read_q ? fill_addr : '0;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  assign HIT_COUNT  = hit_cnt;
  assign MISS_COUNT = miss_cnt;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      valid      <= '0;
      mem_read_q <= 1'b0;
      fill_addr  <= '0;
`ifdef ICACHE_STATS_EN
      hit_cnt    <= 16'd0;
      miss_cnt   <= 16'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!hit) begin
            fill_addr  <= ADDRESS[ADDR_WIDTH-1:4];
            mem_read_q <= 1'b1;
            state      <= S_MREAD;
`ifdef ICACHE_STATS_EN
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
`endif
          end else begin
`ifdef ICACHE_STATS_EN
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
`endif
          end
        end
        S_MREAD: begin
          if (!MEM_BUSYWAIT) begin
            mem_read_q <= 1'b0;
            state      <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          valid[fill_idx] <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; an invalid line is never read as a hit.
  // The block is held in fill_data so memory may drop it after handshake.
  always_ff @(posedge CLK) begin
    if (state == S_MREAD && !MEM_BUSYWAIT) begin
      fill_data <= MEM_READDATA;
    end
    if (state == S_UPDATE) begin
      data_mem[fill_idx] <= fill_data;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard bench for icache_direct with random fetch stream
module tb_icache_direct;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [9:0]   ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  icache_direct #(.ADDR_WIDTH(10), .NUM_BLOCKS(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [127:0] imem [64];
  int           resident [8];
  int           miss_q [$];
  int           lat_q  [$];
  logic [31:0]  exp_q  [$];
  bit           fetching = 1'b0;
  bit           abort    = 1'b0;
  int           mdl_hits;
  int           mdl_misses;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [9:0] a);
    logic [127:0] b;
    b = imem[a[9:4]];
    return b[a[3:2]*32 +: 32];
  endfunction

  // Reference: a block is resident iff it was the last one filled into its line.
  task automatic fetch(input logic [9:0] a, input int lat);
    int blk;
    bit exp_hit;
    int stalls;
    blk     = int'(a[9:4]);
    exp_hit = (resident[blk % 8] == blk);
    stalls  = 0;
    ADDRESS = a;
    exp_q.push_back(ref_word(a));
    if (!exp_hit) begin
      miss_q.push_back(blk);
      lat_q.push_back(lat);
      resident[blk % 8] = blk;
      mdl_misses++;
    end
    fetching = 1'b1;
    @(negedge CLK);
    chk("busywait_first", BUSYWAIT, !exp_hit);
    if (exp_hit) begin
      chk("mem_read_on_hit", MEM_READ, 0);
      chk("mem_addr_idle", MEM_ADDRESS, 0);
    end
    while (BUSYWAIT && stalls < 200) begin
      stalls++;
      @(negedge CLK);
    end
    if (BUSYWAIT) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: addr %0h still stalled after %0d cycles, want release", a, stalls);
      abort = 1'b1;
      fetching = 1'b0;
      return;
    end
    if (!exp_hit) chk("miss_penalty", stalls, lat + 3);
`ifdef ICACHE_STATS_EN
    chk("hit_count", HIT_COUNT, mdl_hits);
    chk("miss_count", MISS_COUNT, mdl_misses);
`endif
    mdl_hits++;
    @(posedge CLK);
    #1;
    fetching = 1'b0;
  endtask

  logic [31:0] mon_exp;
  always @(negedge CLK) begin
    if (fetching && !RESET && !BUSYWAIT) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL instr_unexpected: got %0h want no response", INSTRUCTION);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("instruction", INSTRUCTION, mon_exp);
      end
    end
  end

  // Block memory responder: holds busy for the scheduled latency, then drives
  // the block for one cycle and scrambles the bus afterwards.
  int r_cnt;
  int cur_blk;
  bit r_active = 1'b0;
  bit r_done   = 1'b0;
  always @(negedge CLK) begin
    if (RESET) begin
      r_active     = 1'b0;
      r_done       = 1'b0;
      MEM_BUSYWAIT = 1'b1;
    end else if (r_done) begin
      MEM_BUSYWAIT = 1'b1;
      MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
      r_done       = 1'b0;
    end else if (MEM_READ && !r_active) begin
      if (miss_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mem_read_unexpected: got request for %0h want none", MEM_ADDRESS);
        cur_blk = int'(MEM_ADDRESS);
        r_cnt   = 0;
      end else begin
        cur_blk = miss_q.pop_front();
        r_cnt   = lat_q.pop_front();
        chk("mem_address", MEM_ADDRESS, cur_blk);
      end
      r_active = 1'b1;
      if (r_cnt == 0) begin
        MEM_READDATA = imem[cur_blk];
        MEM_BUSYWAIT = 1'b0;
        r_active     = 1'b0;
        r_done       = 1'b1;
      end
    end else if (r_active) begin
      r_cnt--;
      if (r_cnt == 0) begin
        MEM_READDATA = imem[cur_blk];
        MEM_BUSYWAIT = 1'b0;
        r_active     = 1'b0;
        r_done       = 1'b1;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) resident[i] = -1;
    mdl_hits   = 0;
    mdl_misses = 0;
    exp_q.delete();
    miss_q.delete();
    lat_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busywait"}, BUSYWAIT, 0);
    chk({tag, "_instr"}, INSTRUCTION, 0);
    chk({tag, "_mem_read"}, MEM_READ, 0);
    chk({tag, "_mem_addr"}, MEM_ADDRESS, 0);
`ifdef ICACHE_STATS_EN
    chk({tag, "_hit_count"}, HIT_COUNT, 0);
    chk({tag, "_miss_count"}, MISS_COUNT, 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = {$urandom, $urandom, $urandom, $urandom};
    imem[0] = 128'h0000000C_00000008_00000004_00000001;
    model_reset();
    RESET        = 1'b1;
    ADDRESS      = 10'h000;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Cold miss, same-block hits, conflict eviction, distinct index.
    fetch(10'h000, 5);
    if (!abort) fetch(10'h004, 1);
    if (!abort) fetch(10'h008, 1);
    if (!abort) fetch(10'h00C, 1);
    if (!abort) fetch(10'h080, 2);
    if (!abort) fetch(10'h000, 0);
    if (!abort) fetch(10'h010, 3);
    if (!abort) fetch(10'h000, 1);

    // Reset two cycles into a memory read.
    if (!abort) begin
      ADDRESS = 10'h0C0;
      miss_q.push_back(12);
      lat_q.push_back(6);
      @(posedge CLK);
      @(posedge CLK);
      @(posedge CLK);
      #2;
      chk("mid_miss_mem_read", MEM_READ, 1);
      RESET = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      fetch(10'h000, 2);
    end

    for (int n = 0; n < 400 && !abort; n++) begin
      logic [9:0] a;
      a = {3'(n % 3 == 0 ? $urandom_range(0, 2) : $urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      fetch(a, $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
